// File: rtl/rs_issue_queue.sv
// rs_issue_queue: reservation station with operand wakeup from CDB_N result
// broadcast channels and a registered single-entry issue output.
// Optional build macro RS_OLDEST_FIRST_EN: issue picks the oldest ready entry
// (age matrix) instead of the lowest-index ready entry.
module rs_issue_queue #(
    parameter int DEPTH_BIT = 3,
    parameter int ROB_BIT   = 5,
    parameter int OP_W      = 7,
    parameter int CDB_N     = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_flag,
    input  logic                     disp_valid,
    input  logic [OP_W-1:0]          disp_op,
    input  logic [31:0]              disp_v1,
    input  logic [31:0]              disp_v2,
    input  logic                     disp_q1_busy,
    input  logic                     disp_q2_busy,
    input  logic [ROB_BIT-1:0]       disp_q1,
    input  logic [ROB_BIT-1:0]       disp_q2,
    input  logic [31:0]              disp_imm,
    input  logic [31:0]              disp_pc,
    input  logic [ROB_BIT-1:0]       disp_rob,
    output logic                     full,
    output logic [DEPTH_BIT:0]       count,
    input  logic [CDB_N-1:0]         cdb_valid,
    input  logic [CDB_N*ROB_BIT-1:0] cdb_rob,
    input  logic [CDB_N*32-1:0]      cdb_val,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [OP_W-1:0]          iss_op,
    output logic [31:0]              iss_v1,
    output logic [31:0]              iss_v2,
    output logic [31:0]              iss_imm,
    output logic [31:0]              iss_pc,
    output logic [ROB_BIT-1:0]       iss_rob
);
    localparam int N = 1 << DEPTH_BIT;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [31:0]        v1;
        logic [31:0]        v2;
        logic               q1_busy;
        logic               q2_busy;
        logic [ROB_BIT-1:0] q1;
        logic [ROB_BIT-1:0] q2;
        logic [31:0]        imm;
        logic [31:0]        pc;
        logic [ROB_BIT-1:0] rob;
    } entry_t;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [31:0]        v1;
        logic [31:0]        v2;
        logic [31:0]        imm;
        logic [31:0]        pc;
        logic [ROB_BIT-1:0] rob;
    } issue_t;

    logic [N-1:0]         valid_q, valid_d;
    entry_t               ent_q [N];
    entry_t               ent_d [N];
    logic                 iss_valid_q, iss_valid_d;
    issue_t               iss_q, iss_d;
    logic [N-1:0]         ready;
    logic [N-1:0]         cand;
    logic                 sel_found;
    logic [DEPTH_BIT-1:0] sel_idx;
    logic [DEPTH_BIT-1:0] free_idx;
    logic [DEPTH_BIT:0]   count_v;
    logic                 load;
    logic                 do_disp;

    // Returns {busy, value} after snooping the broadcast buses; lowest channel wins.
    function automatic logic [32:0] snoop(input logic busy, input logic [ROB_BIT-1:0] tag,
                                          input logic [31:0] val, input logic [CDB_N-1:0] cv,
                                          input logic [CDB_N*ROB_BIT-1:0] cr,
                                          input logic [CDB_N*32-1:0] cd);
        logic [32:0] r;
        r = {busy, val};
        if (busy) begin
            for (int k = CDB_N - 1; k >= 0; k--) begin
                if (cv[k] && (cr[k*ROB_BIT +: ROB_BIT] == tag)) r = {1'b0, cd[k*32 +: 32]};
            end
        end
        return r;
    endfunction

    assign full      = &valid_q;
    assign count     = count_v;
    assign load      = !iss_valid_q || iss_ready;
    assign do_disp   = !clear_flag && disp_valid && !full;
    assign iss_valid = iss_valid_q;
    assign iss_op    = iss_q.op;
    assign iss_v1    = iss_q.v1;
    assign iss_v2    = iss_q.v2;
    assign iss_imm   = iss_q.imm;
    assign iss_pc    = iss_q.pc;
    assign iss_rob   = iss_q.rob;

    // Occupancy count, ready vector and lowest free slot from registered state.
    always_comb begin
        count_v  = '0;
        ready    = '0;
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            count_v  = count_v + {{DEPTH_BIT{1'b0}}, valid_q[i]};
            ready[i] = valid_q[i] && !ent_q[i].q1_busy && !ent_q[i].q2_busy;
            if (!valid_q[i]) free_idx = DEPTH_BIT'(i);
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // older_q[j][i] set means entry j was dispatched before entry i.
    logic [N-1:0] older_q [N];
    logic [N-1:0] older_d [N];

    // Keep only ready entries that no other ready entry is older than.
    always_comb begin
        cand = ready;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (ready[j] && older_q[j][i]) cand[i] = 1'b0;
            end
        end
    end

    // Age relation update: a new entry is younger than everyone, a freed row is dropped.
    always_comb begin
        older_d = older_q;
        if (!clear_flag && load && sel_found) older_d[sel_idx] = '0;
        if (do_disp) begin
            for (int j = 0; j < N; j++) older_d[j][free_idx] = (j != int'(free_idx));
            older_d[free_idx] = '0;
        end
    end

    // Age matrix register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < N; i++) older_q[i] <= '0;
        end else if (rdy_in) begin
            older_q <= older_d;
        end
    end
`else
    assign cand = ready;
`endif

    // Pick the lowest-index candidate.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = DEPTH_BIT'(i);
            end
        end
    end

    // Next state: flush, else wakeup, issue-register load and dispatch.
    always_comb begin
        valid_d     = valid_q;
        ent_d       = ent_q;
        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;
        if (clear_flag) begin
            valid_d     = '0;
            iss_valid_d = 1'b0;
            iss_d       = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (valid_q[i]) begin
                    {ent_d[i].q1_busy, ent_d[i].v1} = snoop(ent_q[i].q1_busy, ent_q[i].q1,
                        ent_q[i].v1, cdb_valid, cdb_rob, cdb_val);
                    {ent_d[i].q2_busy, ent_d[i].v2} = snoop(ent_q[i].q2_busy, ent_q[i].q2,
                        ent_q[i].v2, cdb_valid, cdb_rob, cdb_val);
                end
            end
            if (load) begin
                if (sel_found) begin
                    iss_valid_d      = 1'b1;
                    iss_d.op         = ent_q[sel_idx].op;
                    iss_d.v1         = ent_q[sel_idx].v1;
                    iss_d.v2         = ent_q[sel_idx].v2;
                    iss_d.imm        = ent_q[sel_idx].imm;
                    iss_d.pc         = ent_q[sel_idx].pc;
                    iss_d.rob        = ent_q[sel_idx].rob;
                    valid_d[sel_idx] = 1'b0;
                end else begin
                    iss_valid_d = 1'b0;
                    iss_d       = '0;
                end
            end
            if (do_disp) begin
                valid_d[free_idx]     = 1'b1;
                ent_d[free_idx].op    = disp_op;
                ent_d[free_idx].q1    = disp_q1;
                ent_d[free_idx].q2    = disp_q2;
                ent_d[free_idx].imm   = disp_imm;
                ent_d[free_idx].pc    = disp_pc;
                ent_d[free_idx].rob   = disp_rob;
                {ent_d[free_idx].q1_busy, ent_d[free_idx].v1} = snoop(disp_q1_busy, disp_q1,
                    disp_v1, cdb_valid, cdb_rob, cdb_val);
                {ent_d[free_idx].q2_busy, ent_d[free_idx].v2} = snoop(disp_q2_busy, disp_q2,
                    disp_v2, cdb_valid, cdb_rob, cdb_val);
            end
        end
    end

    // State registers: reset wins over everything, rdy_in low freezes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q     <= '0;
            for (int i = 0; i < N; i++) ent_q[i] <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else if (rdy_in) begin
            valid_q     <= valid_d;
            ent_q       <= ent_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
        end
    end
endmodule

// File: tb/tb_rs_issue_queue.sv
// Testbench for rs_issue_queue: directed vector table, corner-case sequences
// and randomized traffic against a slot-array reference model.
`timescale 1ns/1ps
module tb_rs_issue_queue;
    localparam int DB = 3;
    localparam int RB = 5;
    localparam int OW = 7;
    localparam int CN = 2;
    localparam int N  = 8;

    logic           clk_in = 1'b0;
    logic           rst_in, rdy_in, clear_flag;
    logic           disp_valid;
    logic [OW-1:0]  disp_op;
    logic [31:0]    disp_v1, disp_v2, disp_imm, disp_pc;
    logic           disp_q1_busy, disp_q2_busy;
    logic [RB-1:0]  disp_q1, disp_q2, disp_rob;
    logic           full;
    logic [DB:0]    count;
    logic [CN-1:0]  cdb_valid;
    logic [CN*RB-1:0] cdb_rob;
    logic [CN*32-1:0] cdb_val;
    logic           iss_valid, iss_ready;
    logic [OW-1:0]  iss_op;
    logic [31:0]    iss_v1, iss_v2, iss_imm, iss_pc;
    logic [RB-1:0]  iss_rob;

    rs_issue_queue #(.DEPTH_BIT(DB), .ROB_BIT(RB), .OP_W(OW), .CDB_N(CN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy), .disp_q1(disp_q1),
        .disp_q2(disp_q2), .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob(disp_rob),
        .full(full), .count(count), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
        .cdb_val(cdb_val), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .iss_rob(iss_rob)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    logic [RB-1:0] issued [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: slots, lowest free for dispatch, dispatch sequence for age.
    typedef struct packed {
        logic        v;
        logic [6:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic        b1, b2;
        logic [4:0]  q1, q2, rob;
        int unsigned seq;
    } ment_t;

    ment_t       m [N];
    ment_t       mi;
    int unsigned seq_ctr = 0;

    function automatic logic [32:0] cdb_hit(input logic [4:0] tag);
        for (int k = 0; k < CN; k++)
            if (cdb_valid[k] && cdb_rob[k*RB +: RB] == tag) return {1'b1, cdb_val[k*32 +: 32]};
        return '0;
    endfunction

    function automatic int model_count();
        int c = 0;
        foreach (m[i]) if (m[i].v) c++;
        return c;
    endfunction

    task automatic model_edge();
        ment_t n [N];
        ment_t ni;
        logic [32:0] h;
        int sel, f;
        if (rst_in) begin
            foreach (m[i]) m[i] = '0;
            mi = '0;
            return;
        end
        if (!rdy_in) return;
        if (clear_flag) begin
            foreach (m[i]) m[i].v = 1'b0;
            mi = '0;
            return;
        end
        n = m;
        ni = mi;
        foreach (m[i]) begin
            if (m[i].v && m[i].b1) begin
                h = cdb_hit(m[i].q1);
                if (h[32]) begin n[i].b1 = 1'b0; n[i].v1 = h[31:0]; end
            end
            if (m[i].v && m[i].b2) begin
                h = cdb_hit(m[i].q2);
                if (h[32]) begin n[i].b2 = 1'b0; n[i].v2 = h[31:0]; end
            end
        end
        if (!mi.v || iss_ready) begin
            sel = -1;
            foreach (m[i]) begin
                if (m[i].v && !m[i].b1 && !m[i].b2) begin
`ifdef RS_OLDEST_FIRST_EN
                    if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
                    if (sel < 0) sel = i;
`endif
                end
            end
            if (sel >= 0) begin
                ni = m[sel];
                n[sel].v = 1'b0;
            end else begin
                ni = '0;
            end
        end
        if (disp_valid && model_count() < N) begin
            f = -1;
            foreach (m[i]) if (!m[i].v && f < 0) f = i;
            n[f]     = '0;
            n[f].v   = 1'b1;
            n[f].op  = disp_op;
            n[f].imm = disp_imm;
            n[f].pc  = disp_pc;
            n[f].rob = disp_rob;
            n[f].q1  = disp_q1;
            n[f].q2  = disp_q2;
            n[f].seq = seq_ctr++;
            h = cdb_hit(disp_q1);
            if (disp_q1_busy && h[32]) begin n[f].b1 = 1'b0; n[f].v1 = h[31:0]; end
            else begin n[f].b1 = disp_q1_busy; n[f].v1 = disp_v1; end
            h = cdb_hit(disp_q2);
            if (disp_q2_busy && h[32]) begin n[f].b2 = 1'b0; n[f].v2 = h[31:0]; end
            else begin n[f].b2 = disp_q2_busy; n[f].v2 = disp_v2; end
        end
        m = n;
        mi = ni;
    endtask

    // One clock: record handshake, advance model, let DUT take the edge, compare.
    task automatic step();
        if (!rst_in && rdy_in && !clear_flag && iss_valid && iss_ready) issued.push_back(iss_rob);
        model_edge();
        @(posedge clk_in);
        #1;
        chk("m_iss_valid", {31'd0, iss_valid}, {31'd0, mi.v});
        chk("m_iss_op", {25'd0, iss_op}, {25'd0, mi.op});
        chk("m_iss_v1", iss_v1, mi.v1);
        chk("m_iss_v2", iss_v2, mi.v2);
        chk("m_iss_imm", iss_imm, mi.imm);
        chk("m_iss_pc", iss_pc, mi.pc);
        chk("m_iss_rob", {27'd0, iss_rob}, {27'd0, mi.rob});
        chk("m_count", {28'd0, count}, model_count());
        chk("m_full", {31'd0, full}, (model_count() == N) ? 32'd1 : 32'd0);
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clear_flag = 1'b0;
        disp_valid = 1'b0; disp_q1_busy = 1'b0; disp_q2_busy = 1'b0;
        cdb_valid = '0; cdb_rob = '0; cdb_val = '0;
    endtask

    task automatic set_disp(input logic [4:0] rob, input logic b1, input logic [4:0] q1,
                            input logic b2, input logic [4:0] q2,
                            input logic [31:0] v1, input logic [31:0] v2);
        disp_valid = 1'b1; disp_rob = rob;
        disp_q1_busy = b1; disp_q1 = q1; disp_q2_busy = b2; disp_q2 = q2;
        disp_v1 = v1; disp_v2 = v2;
        disp_op  = 7'h13 + {2'b00, rob};
        disp_imm = 32'(rob) * 3;
        disp_pc  = 32'h1000 + 32'(rob) * 4;
    endtask

    task automatic reset_dut();
        idle();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    task automatic drain(input int n);
        idle();
        iss_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct packed {
        logic        rst, rdy, dv, q1b;
        logic [4:0]  q1;
        logic        q2b;
        logic [4:0]  q2;
        logic [31:0] v1, v2;
        logic [4:0]  rob;
        logic [1:0]  cv;
        logic [4:0]  cr0, cr1;
        logic [31:0] cd0, cd1;
        logic        ir, ev;
        logic [31:0] ev1, ev2;
        logic [4:0]  erob;
        logic [3:0]  ecnt;
    } vec_t;

    function automatic vec_t mkv(
        input logic rst, input logic rdy, input logic dv, input logic q1b, input logic [4:0] q1,
        input logic q2b, input logic [4:0] q2, input logic [31:0] v1, input logic [31:0] v2,
        input logic [4:0] rob, input logic [1:0] cv, input logic [4:0] cr0, input logic [4:0] cr1,
        input logic [31:0] cd0, input logic [31:0] cd1, input logic ir, input logic ev,
        input logic [31:0] ev1, input logic [31:0] ev2, input logic [4:0] erob,
        input logic [3:0] ecnt);
        return '{rst, rdy, dv, q1b, q1, q2b, q2, v1, v2, rob, cv, cr0, cr1, cd0, cd1, ir,
                 ev, ev1, ev2, erob, ecnt};
    endfunction

    localparam int NV = 23;
    vec_t vt [NV];

    initial begin
        //           rst rdy dv q1b q1 q2b q2 v1      v2 rob cv     cr0 cr1 cd0     cd1      ir | ev ev1      ev2    erob cnt
        vt[0]  = mkv(1, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  0);
        vt[1]  = mkv(0, 1, 1, 0, 0,  0, 0, 5,      7, 3,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  1);
        vt[2]  = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   1, 5,       7,     3,  0);
        vt[3]  = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  0);
        vt[4]  = mkv(0, 1, 1, 1, 9,  0, 0, 'h111,  2, 6,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  1);
        vt[5]  = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  1);
        vt[6]  = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b10, 9,  9,  'hBAD,  'hDEAD,  1,   0, 0,       0,     0,  1);
        vt[7]  = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   1, 'hDEAD,  2,     6,  0);
        vt[8]  = mkv(0, 1, 1, 0, 0,  1, 4, 1,      0, 7,  2'b01, 4,  0,  'h55,   0,       1,   0, 0,       0,     0,  1);
        vt[9]  = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   1, 1,       'h55,  7,  0);
        vt[10] = mkv(0, 1, 1, 1, 2,  0, 0, 0,      3, 8,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  1);
        vt[11] = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b11, 2,  2,  'hA,    'hB,     1,   0, 0,       0,     0,  1);
        vt[12] = mkv(0, 0, 1, 0, 0,  0, 0, 4,      4, 9,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  1);
        vt[13] = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   1, 'hA,     3,     8,  0);
        vt[14] = mkv(0, 0, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   1, 'hA,     3,     8,  0);
        vt[15] = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  0);
        vt[16] = mkv(0, 1, 1, 1, 12, 0, 0, 0,      0, 10, 2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  1);
        vt[17] = mkv(0, 0, 0, 0, 0,  0, 0, 0,      0, 0,  2'b01, 12, 0,  'h77,   0,       1,   0, 0,       0,     0,  1);
        vt[18] = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  1);
        vt[19] = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b01, 12, 0,  'h78,   0,       1,   0, 0,       0,     0,  1);
        vt[20] = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       0,   1, 'h78,    0,     10, 0);
        vt[21] = mkv(1, 0, 1, 0, 0,  0, 0, 9,      9, 11, 2'b00, 0,  0,  0,      0,       0,   0, 0,       0,     0,  0);
        vt[22] = mkv(0, 1, 0, 0, 0,  0, 0, 0,      0, 0,  2'b00, 0,  0,  0,      0,       1,   0, 0,       0,     0,  0);

        idle();
        iss_ready = 1'b1;
        set_disp(0, 0, 0, 0, 0, 0, 0);
        disp_valid = 1'b0;

        // Directed vector table.
        for (int r = 0; r < NV; r++) begin
            idle();
            set_disp(vt[r].rob, vt[r].q1b, vt[r].q1, vt[r].q2b, vt[r].q2, vt[r].v1, vt[r].v2);
            disp_valid = vt[r].dv;
            rst_in     = vt[r].rst;
            rdy_in     = vt[r].rdy;
            cdb_valid  = vt[r].cv;
            cdb_rob    = {vt[r].cr1, vt[r].cr0};
            cdb_val    = {vt[r].cd1, vt[r].cd0};
            iss_ready  = vt[r].ir;
            step();
            chk($sformatf("vec%0d_valid", r), {31'd0, iss_valid}, {31'd0, vt[r].ev});
            chk($sformatf("vec%0d_v1", r), iss_v1, vt[r].ev1);
            chk($sformatf("vec%0d_v2", r), iss_v2, vt[r].ev2);
            chk($sformatf("vec%0d_rob", r), {27'd0, iss_rob}, {27'd0, vt[r].erob});
            chk($sformatf("vec%0d_count", r), {28'd0, count}, {28'd0, vt[r].ecnt});
        end

        // Fill to full with the output stalled; extra dispatch is ignored.
        reset_dut();
        issued.delete();
        iss_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            idle();
            set_disp(5'(i), 0, 0, 0, 0, i, i + 100);
            step();
        end
        chk("fill_full", {31'd0, full}, 1);
        chk("fill_count", {28'd0, count}, 8);
        idle();
        set_disp(31, 0, 0, 0, 0, 1, 1);
        step();
        chk("fill_ignored_count", {28'd0, count}, 8);
        idle();
        iss_ready = 1'b1;
        step();
        chk("release_count", {28'd0, count}, 7);
        chk("release_full", {31'd0, full}, 0);
`ifdef RS_OLDEST_FIRST_EN
        chk("release_rob", {27'd0, iss_rob}, 2);
`else
        chk("release_rob", {27'd0, iss_rob}, 3);
`endif
        drain(9);
        chk("fill_issue_total", issued.size(), 9);
        foreach (issued[i]) if (issued[i] == 5'd31) chk("fill_no_rob31", {27'd0, issued[i]}, 0);

        // Ordering A: older blocked entry sits in the lower index.
        reset_dut();
        issued.delete();
        iss_ready = 1'b0;
        idle(); set_disp(1, 1, 10, 0, 0, 0, 0); step();
        idle(); set_disp(2, 0, 0, 0, 0, 2, 2);  step();
        idle(); step();
        idle(); set_disp(3, 0, 0, 0, 0, 3, 3);  step();
        idle(); cdb_valid = 2'b01; cdb_rob = {5'd0, 5'd10}; cdb_val = {32'd0, 32'h100}; step();
        drain(4);
        chk("orderA_n", issued.size(), 3);
        chk("orderA_0", {27'd0, issued[0]}, 2);
        chk("orderA_1", {27'd0, issued[1]}, 1);
        chk("orderA_2", {27'd0, issued[2]}, 3);

        // Ordering B: younger ready entry sits in the lower index.
        reset_dut();
        issued.delete();
        iss_ready = 1'b0;
        idle(); set_disp(2, 0, 0, 0, 0, 2, 2);  step();
        idle(); set_disp(1, 1, 10, 0, 0, 0, 0); step();
        idle(); set_disp(3, 0, 0, 0, 0, 3, 3);  step();
        idle(); cdb_valid = 2'b01; cdb_rob = {5'd0, 5'd10}; cdb_val = {32'd0, 32'h100}; step();
        drain(4);
        chk("orderB_n", issued.size(), 3);
        chk("orderB_0", {27'd0, issued[0]}, 2);
`ifdef RS_OLDEST_FIRST_EN
        chk("orderB_1", {27'd0, issued[1]}, 1);
        chk("orderB_2", {27'd0, issued[2]}, 3);
`else
        chk("orderB_1", {27'd0, issued[1]}, 3);
        chk("orderB_2", {27'd0, issued[2]}, 1);
`endif

        // Flush with held output, pending entries and a concurrent broadcast.
        reset_dut();
        iss_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            idle();
            set_disp(5'(i), (i == 5), 20, 0, 0, i, i);
            step();
        end
        chk("preclear_count", {28'd0, count}, 4);
        chk("preclear_valid", {31'd0, iss_valid}, 1);
        idle();
        clear_flag = 1'b1;
        set_disp(9, 0, 0, 0, 0, 9, 9);
        cdb_valid = 2'b01; cdb_rob = {5'd0, 5'd20}; cdb_val = {32'd0, 32'h99};
        step();
        chk("clear_valid", {31'd0, iss_valid}, 0);
        chk("clear_count", {28'd0, count}, 0);
        drain(2);
        chk("postclear_count", {28'd0, count}, 0);
        chk("postclear_valid", {31'd0, iss_valid}, 0);

        // Randomized traffic against the model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst_in     = ($urandom_range(0, 199) == 0);
            rdy_in     = ($urandom_range(0, 9) != 0);
            clear_flag = ($urandom_range(0, 99) == 0);
            set_disp(5'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                     5'($urandom_range(0, 7)), $urandom, $urandom);
            disp_valid = 1'($urandom);
            cdb_valid  = 2'($urandom);
            cdb_rob    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cdb_val    = {$urandom, $urandom};
            iss_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_issue_queue.md
RS_ISSUE_QUEUE -- requirements
Module: rs_issue_queue

Interface
REQ-001 SHALL have parameters: DEPTH_BIT, default 3, log2 entry count; ROB_BIT, default 5, ROB tag width; OP_W, default 7, op field width; CDB_N, default 2, number of result broadcast channels.
REQ-002 SHALL have ports: clk_in  in  1  system clock; rst_in  in  1  reset, synchronous, active-high; rdy_in  in  1  global ready, state frozen when low; clear_flag  in  1  flush all entries.
REQ-003 SHALL have dispatch ports: disp_valid in 1; disp_op in OP_W; disp_v1, disp_v2 in 32 each; disp_q1_busy, disp_q2_busy in 1 each; disp_q1, disp_q2 in ROB_BIT each; disp_imm, disp_pc in 32 each; disp_rob in ROB_BIT; full out 1; count out DEPTH_BIT+1.
REQ-004 SHALL have broadcast ports: cdb_valid in CDB_N; cdb_rob in CDB_N*ROB_BIT; cdb_val in CDB_N*32. Channel k uses slice k of each bus.
REQ-005 SHALL have issue ports: iss_valid out 1; iss_ready in 1; iss_op out OP_W; iss_v1, iss_v2, iss_imm, iss_pc out 32 each; iss_rob out ROB_BIT. All outputs registered.

Function
REQ-006 Entry count SHALL be 2^DEPTH_BIT. Each entry holds valid, op, v1, v2, q1_busy, q2_busy, q1, q2, imm, pc, rob.
REQ-007 full SHALL be 1 when all entries are valid. count SHALL equal the number of valid entries. Both are derived from registered state.
REQ-008 Dispatch occurs on an edge with rdy_in=1, disp_valid=1, full=0 and clear_flag=0. The instruction is written into the lowest-index free entry.
REQ-009 A dispatch while full=1 SHALL be ignored, even if an entry frees on the same edge. The source must hold the instruction and retry.
REQ-010 Dispatch capture: if disp_qX_busy=1 and some cdb_valid[k]=1 with cdb_rob[k]=disp_qX, the entry SHALL store cdb_val[k] with busy=0. Otherwise it stores disp_vX and the busy/tag as given.
REQ-011 Wakeup: on each active edge, every valid entry with qX_busy=1 and a matching valid channel SHALL latch that channel's value and clear qX_busy. This applies to both operands and all channels in parallel.
REQ-012 If several channels match one tag, the lowest channel index SHALL win.
REQ-013 An entry is ready when valid=1, q1_busy=0 and q2_busy=0, evaluated on registered state. An entry woken on edge T becomes selectable from T onward and issues no earlier than edge T+1.
REQ-014 Output register load rule: on an active edge where iss_valid=0 or iss_ready=1, the selected ready entry (if any) SHALL be copied to iss_* with iss_valid=1 and the entry freed.
REQ-015 If that load rule holds but no entry is ready, iss_valid SHALL go 0 and iss_* SHALL be zeroed.
REQ-016 While iss_valid=1 and iss_ready=0, iss_* SHALL hold unchanged and no entry is freed.
REQ-017 Latency: an instruction with both operands ready, dispatched on edge T into an empty queue with iss_ready=1, SHALL present iss_valid=1 after edge T+1. Sustained throughput is one issue per cycle.
REQ-018 A freed entry SHALL be reusable by a dispatch on the following edge.
REQ-019 clear_flag=1 with rdy_in=1 SHALL invalidate all entries and clear iss_valid on that edge. It takes precedence over dispatch, wakeup and issue.
REQ-020 rdy_in=0 SHALL freeze all state; broadcasts arriving during the freeze are not captured.

Reset
REQ-021 rst_in=1 on an edge SHALL clear all entry fields, set iss_valid=0, zero every iss_* output, and give full=0, count=0. It takes priority over all inputs, including rdy_in=0.
REQ-022 Reset mid-operation SHALL discard held issue output and pending entries without emitting them.

Configuration
REQ-023 Macro RS_OLDEST_FIRST_EN, when defined: selection SHALL pick the ready entry dispatched earliest, tracked by a per-entry age relation updated on dispatch and free.
REQ-024 Without RS_OLDEST_FIRST_EN: selection SHALL pick the lowest-index ready entry. No age state is instantiated.

Verification
REQ-025 Reset then dispatch op=0x13, v1=5, v2=7, no deps, rob=3, iss_ready=1 -> iss_valid=1 two edges later with iss_v1=5, iss_v2=7, iss_rob=3; count returns to 0.
REQ-026 Dispatch q1_busy=1, q1=9; then cdb_valid[1]=1, cdb_rob[1]=9, cdb_val[1]=0xDEAD -> iss_v1=0xDEAD, issued one edge after the broadcast.
REQ-027 Dispatch q2=4 on the same edge as cdb_valid[0]=1, cdb_rob[0]=4, cdb_val[0]=0x55 -> entry captures 0x55 and issues; there is no deadlock.
REQ-028 Fill 8 entries with iss_ready=0 -> full=1, count=8; a 9th dispatch is ignored. Release iss_ready for one edge -> one issue, full=0 the next cycle.
REQ-029 Dispatch rob=1 (blocked) into index 0, then rob=2 (ready); issue rob=2; dispatch rob=3 (ready) into index 1; wake rob=1 -> the macro build issues rob=1 before rob=3, the non-macro build issues rob=1 (lowest index) first as well. Repeat with rob=3 placed in the lower index and confirm the orders differ.
REQ-030 Fill 4 entries, hold iss_valid=1, assert clear_flag -> next edge iss_valid=0, count=0, and the broadcast is ignored.
